// File: rtl/memory_stage.sv
// Pipelined memory stage: M register, 1024-byte little-endian data memory and W register.
// Memory-stage status and read data are combinational so they can be forwarded.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        m_bubble,
  input  logic        w_stall,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] M_valE,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM
);

  localparam logic [3:0]  STAT_AOK     = 4'd1;
  localparam logic [3:0]  STAT_ADR     = 4'd3;
  localparam logic [3:0]  ICODE_NOP    = 4'h1;
  localparam logic [3:0]  ICODE_CMOV   = 4'h2;
  localparam logic [3:0]  ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0]  ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0]  ICODE_CALL   = 4'h8;
  localparam logic [3:0]  ICODE_RET    = 4'h9;
  localparam logic [3:0]  ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0]  ICODE_POPQ   = 4'hB;
  localparam logic [3:0]  REG_NONE     = 4'hF;
  localparam logic [63:0] ADDR_LAST    = 64'd1016;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP, cnd: 1'b0,
                                  val_e: 64'd0, val_a: 64'd0,
                                  dst_e: REG_NONE, dst_m: REG_NONE};
  localparam w_reg_t W_BUBBLE = '{stat: STAT_AOK, icode: ICODE_NOP,
                                  val_e: 64'd0, val_m: 64'd0,
                                  dst_e: REG_NONE, dst_m: REG_NONE};

  m_reg_t      m_reg_d, m_reg_q;
  w_reg_t      w_reg_d, w_reg_q;
  logic [7:0]  mem_q [0:1023];
  logic [63:0] mem_addr;
  logic [9:0]  mem_idx;
  logic        mem_rd;
  logic        mem_wr;
  logic        addr_bad;
  logic        mem_we;
  logic [63:0] rd_data;

  // M register next state: a bubble replaces the incoming instruction
  always_comb begin
    m_reg_d = M_BUBBLE;
    if (m_bubble) begin
      m_reg_d = M_BUBBLE;
    end else begin
      m_reg_d = '{stat: e_stat, icode: e_icode, cnd: e_cnd, val_e: e_valE,
                  val_a: e_valA, dst_e: e_dstE, dst_m: e_dstM};
    end
  end

  // Access decode; the address check uses all 64 bits so huge addresses never alias
  always_comb begin
    mem_addr = m_reg_q.val_e;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (m_reg_q.icode)
      ICODE_RMMOVQ, ICODE_CALL, ICODE_PUSHQ: begin
        mem_addr = m_reg_q.val_e;
        mem_wr   = 1'b1;
      end
      ICODE_MRMOVQ: begin
        mem_addr = m_reg_q.val_e;
        mem_rd   = 1'b1;
      end
      ICODE_RET, ICODE_POPQ: begin
        mem_addr = m_reg_q.val_a;
        mem_rd   = 1'b1;
      end
      default: begin
        mem_addr = m_reg_q.val_e;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
      end
    endcase
    mem_idx  = mem_addr[9:0];
    addr_bad = (mem_rd || mem_wr) && (mem_addr > ADDR_LAST);
  end

  // Little-endian 8-byte read; the 10-bit index wraps so it always stays in range
  always_comb begin
    rd_data = 64'd0;
    for (int b = 0; b < 8; b++) begin
      rd_data[8*b +: 8] = mem_q[mem_idx + 10'(b)];
    end
  end

  // Stage status, forwarded read data and write qualification
  always_comb begin
    if (addr_bad) begin
      m_stat = STAT_ADR;
    end else begin
      m_stat = m_reg_q.stat;
    end
    if (mem_rd && !addr_bad) begin
      m_valM = rd_data;
    end else begin
      m_valM = 64'd0;
    end
    mem_we = mem_wr && !addr_bad && (m_reg_q.stat == STAT_AOK) && (w_reg_q.stat == STAT_AOK);
  end

  // W register next state; an untaken conditional move loses its destination
  always_comb begin
    w_reg_d = w_reg_q;
    if (w_stall) begin
      w_reg_d = w_reg_q;
    end else begin
      w_reg_d.stat  = m_stat;
      w_reg_d.icode = m_reg_q.icode;
      w_reg_d.val_e = m_reg_q.val_e;
      w_reg_d.val_m = m_valM;
      w_reg_d.dst_e = ((m_reg_q.icode == ICODE_CMOV) && !m_reg_q.cnd) ? REG_NONE : m_reg_q.dst_e;
      w_reg_d.dst_m = m_reg_q.dst_m;
    end
  end

  // Pipeline registers with synchronous reset to bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg_q <= M_BUBBLE;
      w_reg_q <= W_BUBBLE;
    end else begin
      m_reg_q <= m_reg_d;
      w_reg_q <= w_reg_d;
    end
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 8; b++) begin
        mem_q[mem_idx + 10'(b)] <= m_reg_q.val_a[8*b +: 8];
      end
    end
  end

  assign M_icode = m_reg_q.icode;
  assign M_dstE  = m_reg_q.dst_e;
  assign M_dstM  = m_reg_q.dst_m;
  assign M_valE  = m_reg_q.val_e;
  assign W_stat  = w_reg_q.stat;
  assign W_icode = w_reg_q.icode;
  assign W_dstE  = w_reg_q.dst_e;
  assign W_dstM  = w_reg_q.dst_m;
  assign W_valE  = w_reg_q.val_e;
  assign W_valM  = w_reg_q.val_m;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a byte-array reference model predicts every cycle,
// plus directed spot checks with constants taken straight from the intended behaviour.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic        e_cnd, m_bubble, w_stall;
  logic [63:0] e_valE, e_valA;
  logic [63:0] m_valM, M_valE, W_valE, W_valM;
  logic [3:0]  m_stat, M_icode, M_dstE, M_dstM, W_stat, W_icode, W_dstE, W_dstM;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .m_bubble(m_bubble), .w_stall(w_stall), .m_valM(m_valM), .m_stat(m_stat),
    .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM)
  );

  typedef struct packed {
    logic [3:0] stat; logic [3:0] icode; logic cnd;
    logic [63:0] val_e; logic [63:0] val_a; logic [3:0] dst_e; logic [3:0] dst_m;
  } mi_t;
  typedef struct packed {
    logic [3:0] stat; logic [3:0] icode;
    logic [63:0] val_e; logic [63:0] val_m; logic [3:0] dst_e; logic [3:0] dst_m;
  } wi_t;
  typedef struct packed { logic [3:0] m_stat; logic [63:0] m_valm; mi_t m; wi_t w; } exp_t;
  typedef struct { int cyc; int sel; logic [63:0] val; string name; } spot_t;

  localparam mi_t BUB_M = '{stat: 4'd1, icode: 4'd1, cnd: 1'b0, val_e: 64'd0, val_a: 64'd0,
                            dst_e: 4'hF, dst_m: 4'hF};
  localparam wi_t BUB_W = '{stat: 4'd1, icode: 4'd1, val_e: 64'd0, val_m: 64'd0,
                            dst_e: 4'hF, dst_m: 4'hF};
  localparam int P_MVALM = 0, P_MSTAT = 1, P_MICODE = 2, P_MDSTE = 3, P_WSTAT = 4,
                 P_WICODE = 5, P_WVALE = 6, P_WVALM = 7, P_WDSTE = 8, P_WDSTM = 9;

  mi_t        mdl_m = BUB_M;
  wi_t        mdl_w = BUB_W;
  logic [7:0] mdl_mem [0:1023];
  exp_t       sb_q[$];
  spot_t      spot_q[$];
  int         checks = 0;
  int         passes = 0;
  int         edge_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    else passes++;
  endtask

  // What the memory stage should do with the instruction now held in the model's M slot
  function automatic void m_eval(output logic [3:0] st, output logic [63:0] vm,
                                 output bit commit, output int a);
    bit rd, wr, bad;
    logic [63:0] addr;
    rd   = mdl_m.icode inside {4'h5, 4'h9, 4'hB};
    wr   = mdl_m.icode inside {4'h4, 4'h8, 4'hA};
    addr = (mdl_m.icode inside {4'h9, 4'hB}) ? mdl_m.val_a : mdl_m.val_e;
    bad  = (rd || wr) && (addr > 64'd1016);
    st   = bad ? 4'd3 : mdl_m.stat;
    a    = int'(addr[9:0]);
    vm   = 64'd0;
    if (rd && !bad) for (int k = 0; k < 8; k++) vm[8*k +: 8] = mdl_mem[a + k];
    commit = wr && !bad && (mdl_m.stat == 4'd1) && (mdl_w.stat == 4'd1);
  endfunction

  task automatic tick();
    logic [3:0] st; logic [63:0] vm; bit cm; int a; exp_t e;
    @(posedge clk);
    #1;
    edge_n++;
    if (rst) begin
      mdl_m = BUB_M;
      mdl_w = BUB_W;
    end else begin
      m_eval(st, vm, cm, a);
      if (cm) for (int k = 0; k < 8; k++) mdl_mem[a + k] = mdl_m.val_a[8*k +: 8];
      if (!w_stall)
        mdl_w = '{stat: st, icode: mdl_m.icode, val_e: mdl_m.val_e, val_m: vm,
                  dst_e: (mdl_m.icode == 4'h2 && !mdl_m.cnd) ? 4'hF : mdl_m.dst_e,
                  dst_m: mdl_m.dst_m};
      if (m_bubble) mdl_m = BUB_M;
      else mdl_m = '{stat: e_stat, icode: e_icode, cnd: e_cnd, val_e: e_valE, val_a: e_valA,
                     dst_e: e_dstE, dst_m: e_dstM};
    end
    m_eval(st, vm, cm, a);
    e.m_stat = st; e.m_valm = vm; e.m = mdl_m; e.w = mdl_w;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic cnd,
                       input logic [63:0] ve, input logic [63:0] va, input logic [3:0] de,
                       input logic [3:0] dm, input logic bub, input logic stl, input logic rs);
    e_stat = st; e_icode = ic; e_cnd = cnd; e_valE = ve; e_valA = va;
    e_dstE = de; e_dstM = dm; m_bubble = bub; w_stall = stl; rst = rs;
    tick();
  endtask

  task automatic ins(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                     input logic [3:0] de, input logic [3:0] dm);
    drive(4'd1, ic, 1'b1, ve, va, de, dm, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    ins(4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
  endtask

  task automatic spot(input int cyc, input int sel, input logic [63:0] val, input string name);
    spot_t s;
    s.cyc = cyc; s.sel = sel; s.val = val; s.name = name;
    spot_q.push_back(s);
  endtask

  function automatic logic [63:0] probe(input int sel);
    case (sel)
      P_MVALM:  return m_valM;
      P_MSTAT:  return {60'd0, m_stat};
      P_MICODE: return {60'd0, M_icode};
      P_MDSTE:  return {60'd0, M_dstE};
      P_WSTAT:  return {60'd0, W_stat};
      P_WICODE: return {60'd0, W_icode};
      P_WVALE:  return W_valE;
      P_WVALM:  return W_valM;
      P_WDSTE:  return {60'd0, W_dstE};
      P_WDSTM:  return {60'd0, W_dstM};
      default:  return 64'hDEAD;
    endcase
  endfunction

  // Monitor: one expected record per edge, checked half a cycle later
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("m_stat",  {60'd0, m_stat},  {60'd0, e.m_stat});
      chk("m_valM",  m_valM,           e.m_valm);
      chk("M_icode", {60'd0, M_icode}, {60'd0, e.m.icode});
      chk("M_dstE",  {60'd0, M_dstE},  {60'd0, e.m.dst_e});
      chk("M_dstM",  {60'd0, M_dstM},  {60'd0, e.m.dst_m});
      chk("M_valE",  M_valE,           e.m.val_e);
      chk("W_stat",  {60'd0, W_stat},  {60'd0, e.w.stat});
      chk("W_icode", {60'd0, W_icode}, {60'd0, e.w.icode});
      chk("W_dstE",  {60'd0, W_dstE},  {60'd0, e.w.dst_e});
      chk("W_dstM",  {60'd0, W_dstM},  {60'd0, e.w.dst_m});
      chk("W_valE",  W_valE,           e.w.val_e);
      chk("W_valM",  W_valM,           e.w.val_m);
    end
    for (int i = spot_q.size() - 1; i >= 0; i--) begin
      if (spot_q[i].cyc == edge_n) begin
        chk(spot_q[i].name, probe(spot_q[i].sel), spot_q[i].val);
        spot_q.delete(i);
      end
    end
  end

  initial begin
    int n;
    logic [63:0] addr, va, ve;
    logic [3:0] ic;
    int r;
    // reset
    drive(4'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    drive(4'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
    n = edge_n;
    spot(n, P_MSTAT, 64'd1, "rst_m_stat");   spot(n, P_MVALM, 64'd0, "rst_m_valM");
    spot(n, P_MICODE, 64'd1, "rst_M_icode"); spot(n, P_MDSTE, 64'hF, "rst_M_dstE");
    spot(n, P_WSTAT, 64'd1, "rst_W_stat");   spot(n, P_WVALM, 64'd0, "rst_W_valM");
    spot(n, P_WDSTE, 64'hF, "rst_W_dstE");
    // fill every byte of memory so the model and the DUT agree everywhere
    for (int i = 0; i < 128; i++) ins(4'h4, 64'(8 * i), {$urandom(), $urandom()}, 4'hF, 4'hF);
    nop();
    // store then load, back to back
    ins(4'h4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF);
    ins(4'h5, 64'h40, 64'd0, 4'hF, 4'd3);
    n = edge_n;
    spot(n, P_MVALM, 64'h1122334455667788, "st_ld_m_valM");
    spot(n + 1, P_WVALM, 64'h1122334455667788, "st_ld_W_valM");
    spot(n + 1, P_WDSTM, 64'd3, "st_ld_W_dstM");
    // boundary addresses
    ins(4'h4, 64'd1016, 64'hA5A5_0101_C3C3_7E7E, 4'hF, 4'hF);
    ins(4'h5, 64'd1016, 64'd0, 4'hF, 4'd1);
    spot(edge_n, P_MSTAT, 64'd1, "addr1016_stat");
    spot(edge_n, P_MVALM, 64'hA5A5_0101_C3C3_7E7E, "addr1016_valM");
    ins(4'h5, 64'd1017, 64'd0, 4'hF, 4'd1);
    n = edge_n;
    spot(n, P_MSTAT, 64'd3, "addr1017_stat");
    spot(n, P_MVALM, 64'd0, "addr1017_valM");
    spot(n + 1, P_WSTAT, 64'd3, "addr1017_W_stat");
    nop(); nop();
    ins(4'hA, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0BAD_0BAD_0BAD_0BAD, 4'd4, 4'hF);
    spot(edge_n, P_MSTAT, 64'd3, "push_huge_stat");
    nop(); nop();
    ins(4'h5, 64'd1016, 64'd0, 4'hF, 4'd1);
    spot(edge_n, P_MVALM, 64'hA5A5_0101_C3C3_7E7E, "push_huge_nowrite");
    nop();
    // write suppressed while an exception status is held in W
    ins(4'h4, 64'h80, 64'h8080_1234_5678_8080, 4'hF, 4'hF);
    nop(); nop();
    ins(4'h5, 64'd1017, 64'd0, 4'hF, 4'hF);
    ins(4'h4, 64'h80, 64'hFFFF_0000_FFFF_0000, 4'hF, 4'hF);
    drive(4'd1, 4'h1, 1'b1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
    n = edge_n;
    spot(n, P_WSTAT, 64'd3, "stall_W_stat");
    spot(n, P_WICODE, 64'h5, "stall_W_icode");
    spot(n, P_WVALE, 64'd1017, "stall_W_valE");
    nop(); nop();
    ins(4'h5, 64'h80, 64'd0, 4'hF, 4'hF);
    spot(edge_n, P_MVALM, 64'h8080_1234_5678_8080, "exc_nowrite");
    nop();
    // bubble replaces a pushq
    ins(4'h4, 64'h100, 64'h0100_0100_0100_0100, 4'hF, 4'hF);
    nop(); nop();
    drive(4'd1, 4'hA, 1'b1, 64'h100, 64'h7777_6666_5555_4444, 4'd4, 4'hF, 1'b1, 1'b0, 1'b0);
    spot(edge_n, P_MICODE, 64'd1, "bubble_M_icode");
    spot(edge_n, P_MDSTE, 64'hF, "bubble_M_dstE");
    nop();
    ins(4'h5, 64'h100, 64'd0, 4'hF, 4'hF);
    spot(edge_n, P_MVALM, 64'h0100_0100_0100_0100, "bubble_nowrite");
    nop();
    // reset while a store sits in M
    ins(4'h4, 64'h180, 64'h1800_1800_1800_1800, 4'hF, 4'hF);
    nop(); nop();
    ins(4'h4, 64'h180, 64'hDEAD_BEEF_DEAD_BEEF, 4'd5, 4'd6);
    drive(4'd2, 4'h4, 1'b1, 64'h180, 64'd0, 4'd5, 4'd6, 1'b1, 1'b0, 1'b1);
    n = edge_n;
    spot(n, P_MICODE, 64'd1, "rstmid_M_icode"); spot(n, P_MDSTE, 64'hF, "rstmid_M_dstE");
    spot(n, P_WSTAT, 64'd1, "rstmid_W_stat");   spot(n, P_WICODE, 64'd1, "rstmid_W_icode");
    spot(n, P_WVALM, 64'd0, "rstmid_W_valM");   spot(n, P_WDSTM, 64'hF, "rstmid_W_dstM");
    nop();
    ins(4'h5, 64'h180, 64'd0, 4'hF, 4'hF);
    spot(edge_n, P_MVALM, 64'h1800_1800_1800_1800, "rstmid_nowrite");
    // conditional moves
    drive(4'd1, 4'h2, 1'b0, 64'h55, 64'd0, 4'd2, 4'hF, 1'b0, 1'b0, 1'b0);
    spot(edge_n, P_MDSTE, 64'd2, "cmov_nt_M_dstE");
    spot(edge_n + 1, P_WDSTE, 64'hF, "cmov_nt_W_dstE");
    drive(4'd1, 4'h2, 1'b1, 64'h66, 64'd0, 4'd2, 4'hF, 1'b0, 1'b0, 1'b0);
    spot(edge_n + 1, P_WDSTE, 64'd2, "cmov_t_W_dstE");
    nop(); nop();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ic = 4'($urandom_range(0, 11));
      r = int'($urandom_range(0, 99));
      if (r < 80) addr = 64'($urandom_range(0, 1016));
      else if (r < 90) addr = 64'($urandom_range(1017, 1030));
      else if (r < 95) addr = 64'hFFFF_FFFF_FFFF_FFF8;
      else addr = {$urandom(), $urandom()};
      if (ic == 4'h9 || ic == 4'hB) begin va = addr; ve = {$urandom(), $urandom()}; end
      else begin ve = addr; va = {$urandom(), $urandom()}; end
      drive(($urandom_range(0, 99) < 90) ? 4'd1 : 4'($urandom_range(2, 4)), ic,
            1'($urandom_range(0, 1)), ve, va, 4'($urandom()), 4'($urandom()),
            ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end
    nop(); nop(); nop();
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    chk("spots_drained", 64'(spot_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 clk  input  1  Single clock; every state element updates on the rising edge.
REQ-002 rst  input  1  Reset; synchronous and active-high.
REQ-003 e_stat  input  4  Execute-stage status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-004 e_icode  input  4  Execute-stage instruction code.
REQ-005 e_cnd  input  1  Condition result from execute.
REQ-006 e_valE  input  64  ALU result or address from execute.
REQ-007 e_valA  input  64  Store data, or stack pointer for popq/ret.
REQ-008 e_dstE, e_dstM  input  4 each  Destination register IDs; 0xF means none.
REQ-009 m_bubble  input  1  Load a bubble into the M register at the next edge.
REQ-010 w_stall  input  1  Hold the W register at the next edge.
REQ-011 m_valM  output  64  Combinational read data, used for forwarding.
REQ-012 m_stat  output  4  Combinational memory-stage status.
REQ-013 M_icode, M_dstE, M_dstM, M_valE  output  4/4/4/64  M register contents, used for forwarding and hazard control.
REQ-014 W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM  output  4/4/4/4/64/64  W register contents.

Function
REQ-015 M register captures {e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM} on each edge.
- Priority: rst first, then m_bubble, then normal capture.
REQ-016 A bubble loads M with:
- stat=1, icode=1 (nop), cnd=0, valE=0, valA=0, dstE=0xF, dstM=0xF.
REQ-017 cmovXX with M_cnd=0 reaches W with dstE=0xF; the M stage does not alter dstE otherwise.
REQ-018 Data memory is 1024 bytes, byte-addressed, little-endian, accessed 8 bytes at a time.
REQ-019 mem_addr = M_valE for icode 4, 5, 8 and 0xA; mem_addr = M_valA for icode 9 and 0xB.
REQ-020 Read is enabled for icode 5, 9 and 0xB; write is enabled for icode 4, 8 and 0xA; write data = M_valA.
REQ-021 An address is invalid when the access is enabled and mem_addr > 1016 (unsigned, full 64-bit compare, so no wrap-around).
REQ-022 m_stat = 3 (ADR) when the address is invalid; otherwise m_stat = M_stat.
REQ-023 m_valM = bytes [addr .. addr+7] when a read is enabled and the address is valid; otherwise m_valM = 0.
REQ-024 A write commits at the edge that ends the cycle, only if all of these hold:
- the address is valid;
- M_stat = 1;
- W_stat = 1 (no write after an exception has reached W).
REQ-025 A write is not gated by w_stall or m_bubble.
REQ-026 W register captures {m_stat, M_icode, M_valE, m_valM, M_dstE (after REQ-017), M_dstM} on each edge.
- Priority: rst first, then w_stall (hold), then normal capture.
REQ-027 Latency:
- Inputs presented before edge N appear on M_* after edge N.
- The same instruction appears on W_* after edge N+1.
- A store from that instruction is visible to a read in the following cycle.
REQ-028 When a read and a write target overlapping bytes in consecutive cycles, the read returns the newly written data.

Reset
REQ-029 With rst high at an edge, M and W load the bubble values of REQ-016, with W_valM=0.
- m_bubble and w_stall are ignored during reset.
REQ-030 Reset does not clear memory contents; no memory write commits at an edge where rst is high.
REQ-031 After reset, m_stat=1, m_valM=0, and all outputs are defined.

Verification
REQ-032 Store then load:
- rmmovq with e_valE=0x40, e_valA=0x1122334455667788;
- next cycle mrmovq with e_valE=0x40, e_dstM=3;
- response: m_valM=0x1122334455667788, then W_valM equal to it with W_dstM=3.
REQ-033 Boundary addresses:
- mrmovq with e_valE=1016 gives m_stat=1;
- mrmovq with e_valE=1017 gives m_stat=3, m_valM=0, then W_stat=3;
- pushq with e_valE=0xFFFFFFFFFFFFFFF8 gives m_stat=3 and commits no write.
REQ-034 Suppression after exception:
- W_stat=3 is held by w_stall=1 while an rmmovq to 0x80 sits in M;
- response: location 0x80 is unchanged and W holds its previous values.
REQ-035 Bubble insertion:
- m_bubble=1 while e_icode=0xA;
- response: M_icode=1, M_dstE=0xF, and no write commits.
REQ-036 Reset mid-operation:
- rst high at the same edge as an rmmovq in M, with m_bubble=1;
- response: no write commits, and M/W hold bubble values.
REQ-037 Conditional move not taken:
- cmovXX with e_cnd=0 and e_dstE=2;
- response: W_dstE=0xF.
